// File: rtl/serial_deser5.sv
// serial_deser5: oversampled UART-style receiver for 5-bit words with a 2-entry buffer
// and sticky frame/overrun flags. Define SERIAL_DESER5_PARITY_EN to add an odd-parity bit.
module serial_deser5 #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_16_x_baud,
  input  logic       serial_in,
  input  logic       read_strobe,
  input  logic       clear_errors,
  output logic [4:0] data_out,
  output logic       data_present,
  output logic       buffer_full,
  output logic       frame_error,
  output logic       overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_q;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [4:0]      shift_q, shift_d;
  logic [4:0]      head_q, head_d, tail_q, tail_d;
  logic [1:0]      count_q, count_d;
  logic            present_q, full_q, fe_q, ov_q;
  logic            push, pop, set_fe, set_ov, word_ok;

`ifdef SERIAL_DESER5_PARITY_EN
  logic par_q, par_d;
  assign word_ok = ^{shift_q, par_q};
`else
  assign word_ok = 1'b1;
`endif

  // Two-flop synchronizer; idles high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the
      // two stages really form a two-cycle delay instead of collapsing into one.
      sync1_q <= serial_in;
      rx_q    <= sync1_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left one
    // unassigned would infer a latch.
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
`ifdef SERIAL_DESER5_PARITY_EN
    par_d   = par_q;
`endif
    push    = 1'b0;
    set_fe  = 1'b0;
    if (en_16_x_baud) begin
      case (state_q)
        S_IDLE: if (!rx_q) begin
          state_d = S_START;
          tcnt_d  = '0;
        end
        S_START: if (tcnt_q == T_HALF) begin
          tcnt_d  = '0;
          bcnt_d  = '0;
          state_d = rx_q ? S_IDLE : S_DATA;
        end else tcnt_d = tcnt_q + TW'(1);
        S_DATA: if (tcnt_q == T_FULL) begin
          shift_d[bcnt_q] = rx_q;
          tcnt_d          = '0;
          if (bcnt_q == 3'd4) begin
`ifdef SERIAL_DESER5_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else bcnt_d = bcnt_q + 3'd1;
        end else tcnt_d = tcnt_q + TW'(1);
`ifdef SERIAL_DESER5_PARITY_EN
        S_PARITY: if (tcnt_q == T_FULL) begin
          par_d   = rx_q;
          tcnt_d  = '0;
          state_d = S_STOP;
        end else tcnt_d = tcnt_q + TW'(1);
`endif
        S_STOP: if (tcnt_q == T_FULL) begin
          tcnt_d = '0;
          if (!rx_q) begin
            set_fe  = 1'b1;
            state_d = S_WAIT_HIGH;
          end else begin
            set_fe  = !word_ok;
            push    = word_ok;
            state_d = S_IDLE;
          end
        end else tcnt_d = tcnt_q + TW'(1);
        S_WAIT_HIGH: if (rx_q) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Buffer: head_q is always the oldest word, or zero when empty.
  always_comb begin
    pop     = read_strobe && (count_q != 2'd0);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    set_ov  = 1'b0;
    case (count_q)
      2'd0: if (push) begin
        head_d  = shift_q;
        count_d = 2'd1;
      end
      2'd1: begin
        if (push && pop) head_d = shift_q;
        else if (push) begin
          tail_d  = shift_q;
          count_d = 2'd2;
        end else if (pop) begin
          head_d  = '0;
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (push && pop) begin
          head_d = tail_q;
          tail_d = shift_q;
        end else if (push) set_ov = 1'b1;
        else if (pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
`ifdef SERIAL_DESER5_PARITY_EN
      par_q     <= 1'b0;
`endif
      // NOTE: the buffer entries are reset as well, because data_out is read directly
      // from the head entry and must be zero whenever the buffer is empty.
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      present_q <= 1'b0;
      full_q    <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
`ifdef SERIAL_DESER5_PARITY_EN
      par_q     <= par_d;
`endif
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      present_q <= (count_d != 2'd0);
      full_q    <= (count_d == 2'd2);
      fe_q      <= (fe_q & ~clear_errors) | set_fe;
      ov_q      <= (ov_q & ~clear_errors) | set_ov;
    end
  end

  assign data_out     = head_q;
  assign data_present = present_q;
  assign buffer_full  = full_q;
  assign frame_error  = fe_q;
  assign overrun      = ov_q;

endmodule

// File: tb/tb_serial_deser5.sv
// Bench for serial_deser5: directed frames, a tick-counting reference model compared
// every cycle, and hand-computed expectations after each scenario.
module tb_serial_deser5;

  localparam int OS      = 16;
  localparam int HALF    = OS / 2;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK = OS * TICK_DIV;
`ifdef SERIAL_DESER5_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB     = PAR ? 6 : 5;
  localparam int STOP_E = HALF + (NB + 1) * OS;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       en_16_x_baud = 1'b0;
  logic       serial_in = 1'b1;
  logic       read_strobe = 1'b0;
  logic       clear_errors = 1'b0;
  logic [4:0] data_out;
  logic       data_present, buffer_full, frame_error, overrun;

  int n_checks = 0;
  int n_errors = 0;

  serial_deser5 #(.OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en_16_x_baud (en_16_x_baud),
    .serial_in    (serial_in),
    .read_strobe  (read_strobe),
    .clear_errors (clear_errors),
    .data_out     (data_out),
    .data_present (data_present),
    .buffer_full  (buffer_full),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      en_16_x_baud = (cnt == TICK_DIV - 1);
      cnt = (cnt + 1) % TICK_DIV;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: counts ticks since start detection and samples at
  // HALF + k*OS, with a queue standing in for the buffer.
  logic       m_s1 = 1'b1, m_rx = 1'b1;
  int         m_phase = 0;  // 0 idle, 1 receiving, 2 waiting for line high
  int         m_e = 0;
  int         m_k;
  logic [5:0] m_bits = '0;
  int         exp_q[$];
  logic       m_fe = 1'b0, m_ov = 1'b0;
  logic       m_push, m_setfe, m_setov, m_pop;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_s1 = 1'b1; m_rx = 1'b1; m_phase = 0; m_e = 0;
      exp_q.delete(); m_fe = 1'b0; m_ov = 1'b0;
    end else begin
      m_push = 1'b0; m_setfe = 1'b0; m_setov = 1'b0;
      if (en_16_x_baud) begin
        if (m_phase == 0) begin
          if (!m_rx) begin m_phase = 1; m_e = 0; end
        end else if (m_phase == 1) begin
          m_e++;
          if (m_e == HALF) begin
            if (m_rx) m_phase = 0;
          end else if ((m_e - HALF) % OS == 0) begin
            m_k = (m_e - HALF) / OS;
            if (m_k <= NB) m_bits[m_k-1] = m_rx;
            else if (!m_rx) begin
              m_setfe = 1'b1; m_phase = 2;
            end else begin
              m_phase = 0;
              if (PAR && !(^m_bits)) m_setfe = 1'b1;
              else m_push = 1'b1;
            end
          end
        end else if (m_rx) m_phase = 0;
      end
      m_pop = read_strobe && (exp_q.size() > 0);
      if (m_pop) void'(exp_q.pop_front());
      if (m_push) begin
        if (exp_q.size() < 2) exp_q.push_back(int'(m_bits[4:0]));
        else m_setov = 1'b1;
      end
      if (clear_errors) begin m_fe = 1'b0; m_ov = 1'b0; end
      if (m_setfe) m_fe = 1'b1;
      if (m_setov) m_ov = 1'b1;
      m_rx = m_s1;
      m_s1 = serial_in;
    end
  end

  initial forever begin
    @(negedge clk);
    check("cyc_data_out", 32'(data_out), (exp_q.size() > 0) ? exp_q[0] : 0);
    check("cyc_data_present", 32'(data_present), 32'(exp_q.size() > 0));
    check("cyc_buffer_full", 32'(buffer_full), 32'(exp_q.size() == 2));
    check("cyc_frame_error", 32'(frame_error), 32'(m_fe));
    check("cyc_overrun", 32'(overrun), 32'(m_ov));
  end

  task automatic drive_bit(input logic v);
    @(negedge clk);
    serial_in = v;
    repeat (BIT_CLK - 1) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    repeat (n) drive_bit(1'b1);
  endtask

  function automatic logic good_par(input logic [4:0] w);
    return ~(^w);
  endfunction

  task automatic send_frame(input logic [4:0] w, input logic stop, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(w[i]);
    if (PAR) drive_bit(par);
    drive_bit(stop);
  endtask

  task automatic send_ok(input logic [4:0] w);
    send_frame(w, 1'b1, good_par(w));
    idle_bits(1);
  endtask

  task automatic pulse_read();
    @(negedge clk); read_strobe = 1'b1;
    @(negedge clk); read_strobe = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear_errors = 1'b1;
    @(negedge clk); clear_errors = 1'b0;
  endtask

  // Leaves the caller just after a negedge whose following posedge samples the stop bit.
  task automatic wait_push_edge();
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(m_phase == 1 && m_e == STOP_E - 1 && en_16_x_baud) && n < 2000);
    check("push_edge_found", 32'(n < 2000), 1);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_data_present", 32'(data_present), 0);
    check("rst_buffer_full", 32'(buffer_full), 0);
    check("rst_frame_error", 32'(frame_error), 0);
    check("rst_overrun", 32'(overrun), 0);
    @(posedge clk); #2 reset_n = 1'b1;
    idle_bits(1);

    // Single word
    send_ok(5'h15);
    check("single_data", 32'(data_out), 32'h15);
    check("single_present", 32'(data_present), 1);
    check("single_full", 32'(buffer_full), 0);
    pulse_read();
    check("single_read_data", 32'(data_out), 0);
    check("single_read_present", 32'(data_present), 0);

    // Buffer full and overrun
    send_ok(5'h01);
    send_ok(5'h1E);
    check("full_after_two", 32'(buffer_full), 1);
    check("no_ov_yet", 32'(overrun), 0);
    send_ok(5'h0A);
    check("ov_set", 32'(overrun), 1);
    check("ov_head", 32'(data_out), 32'h01);
    pulse_read();
    check("ov_second", 32'(data_out), 32'h1E);
    pulse_read();
    check("ov_empty", 32'(data_present), 0);
    pulse_read();
    check("ov_empty_read", 32'(data_out), 0);
    pulse_clear();
    check("ov_cleared", 32'(overrun), 0);

    // Bad stop bit, line held low, then a good word
    send_frame(5'h07, 1'b0, good_par(5'h07));
    drive_bit(1'b0);
    drive_bit(1'b0);
    check("bad_stop_fe", 32'(frame_error), 1);
    check("bad_stop_not_buffered", 32'(data_present), 0);
    idle_bits(1);
    send_ok(5'h03);
    check("after_break_data", 32'(data_out), 32'h03);
    pulse_read();
    pulse_clear();
    check("fe_cleared", 32'(frame_error), 0);

    // Start glitch of 5 ticks
    @(negedge clk); serial_in = 1'b0;
    repeat (5 * TICK_DIV - 1) @(negedge clk);
    serial_in = 1'b1;
    idle_bits(2);
    check("glitch_no_word", 32'(data_present), 0);
    check("glitch_no_fe", 32'(frame_error), 0);
    send_ok(5'h0C);
    check("glitch_then_word", 32'(data_out), 32'h0C);
    pulse_read();

    // Push and read on the same edge with one word buffered
    send_ok(5'h05);
    fork
      send_ok(5'h1A);
      begin
        wait_push_edge();
        read_strobe = 1'b1;
        @(negedge clk); read_strobe = 1'b0;
      end
    join
    check("push_pop_present", 32'(data_present), 1);
    check("push_pop_full", 32'(buffer_full), 0);
    check("push_pop_head", 32'(data_out), 32'h1A);
    send_ok(5'h02);
    check("refill_full", 32'(buffer_full), 1);
    // Overrun set and clear_errors on the same edge
    fork
      send_ok(5'h04);
      begin
        wait_push_edge();
        clear_errors = 1'b1;
        @(negedge clk); clear_errors = 1'b0;
      end
    join
    check("set_beats_clear", 32'(overrun), 1);
    pulse_read();
    check("order_second", 32'(data_out), 32'h02);
    pulse_read();
    pulse_clear();

    // Reset during d2
    send_ok(5'h09);
    check("pre_reset_word", 32'(data_out), 32'h09);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(negedge clk); serial_in = 1'b1;
    repeat (30) @(negedge clk);
    @(posedge clk); #2 reset_n = 1'b0;
    #1;
    check("midrst_data_out", 32'(data_out), 0);
    check("midrst_present", 32'(data_present), 0);
    check("midrst_full", 32'(buffer_full), 0);
    check("midrst_fe", 32'(frame_error), 0);
    check("midrst_ov", 32'(overrun), 0);
    repeat (10) @(negedge clk);
    @(posedge clk); #2 reset_n = 1'b1;
    idle_bits(2);
    send_ok(5'h11);
    check("post_reset_word", 32'(data_out), 32'h11);
    check("post_reset_fe", 32'(frame_error), 0);
    pulse_read();

`ifdef SERIAL_DESER5_PARITY_EN
    send_frame(5'h03, 1'b1, 1'b1);
    idle_bits(1);
    check("par_ok_data", 32'(data_out), 32'h03);
    check("par_ok_fe", 32'(frame_error), 0);
    pulse_read();
    send_frame(5'h03, 1'b1, 1'b0);
    idle_bits(1);
    check("par_bad_fe", 32'(frame_error), 1);
    check("par_bad_dropped", 32'(data_present), 0);
    pulse_clear();
`endif

    idle_bits(1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_deser5.md
# serial_deser5

Serial-to-parallel frame receiver that recovers 5-bit words from an asynchronous, UART-style serial line and presents them to a KCPSM3 input port. It is the receive-direction counterpart of the 5-input combinational gate primitives: one serial wire in, five parallel data bits out.
- Oversampled by a shared `en_16_x_baud` enable.
- Buffers up to two words.
- Flags framing and overrun errors for firmware polling.

## Interface
- `OVERSAMPLE`, 16: enable ticks per bit. Must be even and ≥4.
- `clk` in 1: system clock. All flops are rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `en_16_x_baud` in 1: single-cycle sample enable, `OVERSAMPLE` pulses per bit period.
- `serial_in` in 1: asynchronous serial line, idle high.
- `read_strobe` in 1: pops the oldest buffered word, one `clk` wide.
- `clear_errors` in 1: clears the sticky error flags, one `clk` wide.
- `data_out` out 5: oldest buffered word. 0 when the buffer is empty.
- `data_present` out 1: buffer holds ≥1 word.
- `buffer_full` out 1: buffer holds 2 words.
- `frame_error` out 1: sticky; stop bit sampled low.
- `overrun` out 1: sticky; a word arrived while the buffer was full.

## Operation
- **Frame format:** start bit (0), then d0..d4 LSB first, optional parity bit, then stop bit (1).
- **Input synchronizer:** 2 flops, reset to 1. The FSM sees only the synchronized value `rx`.
- **Tick counter:** `tcnt`, width clog2(`OVERSAMPLE`), advances only on `en_16_x_baud`. Bit counter `bcnt` is 0..4.
- **FSM states:**
  - IDLE: on a tick with `rx`=0, go to START with `tcnt`=0.
  - START: when `tcnt` reaches `OVERSAMPLE`/2−1 on a tick, sample `rx`.
    - `rx`=1 (glitch): return to IDLE.
    - `rx`=0: go to DATA with `tcnt`=0 and `bcnt`=0.
  - DATA: each time `tcnt` reaches `OVERSAMPLE`−1 on a tick, shift `rx` into `shift[bcnt]`.
    - After `bcnt`=4, go to PARITY if the parity macro is defined, otherwise to STOP.
  - PARITY: at full-bit count, latch the parity bit, then go to STOP.
  - STOP: at full-bit count, sample `rx`.
    - `rx`=1 and the word is valid: push the word into the buffer, go to IDLE.
    - `rx`=0: set `frame_error`, discard the word, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx`=1 is seen on a tick, then go to IDLE. This prevents a break condition from retriggering reception.
- **Buffer:** 2-entry FIFO with a count of 0..2.
  - Push when full: word dropped, `overrun` set, contents unchanged.
  - `read_strobe` when empty: ignored.
  - Push and read in the same cycle with count 1 or 2: both occur, count unchanged, order preserved.
  - Push and read in the same cycle with count 0: push only.
- **Error flags:**
  - Set has priority over a same-cycle `clear_errors`.
  - Flags are cleared only by `clear_errors` or reset.
- **Reset mid-frame:** any in-progress frame is abandoned. The FSM resumes in IDLE, and the receiver next re-synchronizes on a falling edge.

## Timing
- **Reset values:**
  - Outputs: `data_out`=0, `data_present`=0, `buffer_full`=0, `frame_error`=0, `overrun`=0.
  - Internal: FSM=IDLE, counters=0, synchronizer=1.
- **Sample points:** bits are sampled at mid-bit, `OVERSAMPLE`/2 ticks after start detection plus k·`OVERSAMPLE` ticks. Start detection itself lags the line by 2 `clk` for the synchronizer plus up to 1 tick.
- **Write latency:** `data_present` and `data_out` update on the `clk` edge after the tick that samples a valid stop bit.
- **Read latency:** `read_strobe` at edge N gives the next word, or 0, on `data_out` and updated flags after edge N.
- **Error latency:** `frame_error` and `overrun` assert on the same edge that the push would have occurred.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- Macro: `SERIAL_DESER5_PARITY_EN`.
- **Defined:**
  - The PARITY state is present and the frame is 8 bits long.
  - Odd parity over d0..d4 plus the parity bit is required.
  - A mismatch is treated as a framing fault: `frame_error` is set and the word is discarded.
  - The stop bit is still checked. After a parity mismatch the FSM goes to IDLE if stop=1, or WAIT_HIGH if stop=0.
- **Undefined:** no PARITY state, a 7-bit frame, and no parity logic is synthesized.

## Test plan
- **Single word:** `OVERSAMPLE`=16, tick every 4 `clk`; send 0x15 with a valid frame → after the stop sample, `data_out`=0x15, `data_present`=1, `buffer_full`=0; after `read_strobe`, `data_out`=0, `data_present`=0.
- **Buffer full and overrun:** send 0x01, 0x1E, 0x0A with no reads → `buffer_full`=1 after the second word; after the third, `overrun`=1 and reads return 0x01 then 0x1E only.
- **Bad stop bit:** send 0x07 with stop=0, hold the line low for 3 bit times, then send 0x03 → `frame_error`=1, 0x07 is never buffered, and 0x03 is received correctly afterwards.
- **Start glitch:** a low pulse of 5 ticks on the idle line → no word, no error, FSM back in IDLE.
- **Simultaneous push, read, and clear:** `read_strobe` asserted on the push cycle with count=1 → count stays 1 and the new word is at the head after the pop. `clear_errors` asserted in the same cycle as an overrun set → `overrun` remains 1.
- **Reset and parity:** assert `reset_n`=0 during d2 → all outputs are 0 immediately; the next full frame 0x11 is received correctly. With `SERIAL_DESER5_PARITY_EN` defined: 0x03 with parity=1 is accepted; 0x03 with parity=0 sets `frame_error`.
